// File: rtl/lcd_pixel_serializer_if.sv
// DMA write channel of the LCD pixel serializer: the DMA side offers 32-bit
// pixel words with a valid strobe, and the serializer answers with ready.
interface lcd_pixel_serializer_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_pixel_serializer.sv
// LCD pixel serializer: buffers DMA pixel words in a FIFO, unpacks one word at
// a time into pixels of the selected depth (1/2/4/8 grayscale, RGB565, 24-bit)
// and drives one registered 24-bit pixel per active-pixel strobe.
module lcd_pixel_serializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int WM_LEVEL   = 4
) (
  input  logic                          pixel_clk,
  input  logic                          rst,
  input  logic                          lcd_en,
  input  logic [2:0]                    lcd_bpp,
  input  logic                          bepo,
  input  logic                          bgr,
  lcd_pixel_serializer_if.slave         wr,
  input  logic                          pixel_disp_on,
  input  logic                          frame_start,
  input  logic                          underflow_clr,
  output logic [23:0]                   LCDVD,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dma_req,
  output logic                          underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Pixel width in bits for a bpp code; codes above 5 behave as 24 bpp.
  function automatic logic [5:0] bpp_bits(input logic [2:0] code);
    case (code)
      3'd0:    bpp_bits = 6'd1;
      3'd1:    bpp_bits = 6'd2;
      3'd2:    bpp_bits = 6'd4;
      3'd3:    bpp_bits = 6'd8;
      3'd4:    bpp_bits = 6'd16;
      default: bpp_bits = 6'd24;
    endcase
  endfunction

  // Extract pixel[idx] from a word and expand it to {R,G,B} bytes.
  function automatic logic [23:0] pixel_fmt(input logic [31:0] w, input logic [4:0] idx,
                                            input logic [2:0] code, input logic be,
                                            input logic swap);
    logic [10:0] bits;
    logic [10:0] lo;
    logic [31:0] sh;
    logic [7:0]  r, g, b;
    bits = {5'd0, bpp_bits(code)};
    // bepo=1 counts pixels down from bit 31; a bpp change mid-word may wrap lo,
    // which only yields an undefined pixel value.
    lo   = be ? (11'd32 - ({6'd0, idx} + 11'd1) * bits) : {6'd0, idx} * bits;
    sh   = w >> lo;
    case (code)
      3'd0:    begin g = {8{sh[0]}};   r = g; b = g; end
      3'd1:    begin g = {4{sh[1:0]}}; r = g; b = g; end
      3'd2:    begin g = {2{sh[3:0]}}; r = g; b = g; end
      3'd3:    begin g = sh[7:0];      r = g; b = g; end
      3'd4:    begin
        r = {sh[15:11], sh[15:13]};
        g = {sh[10:5],  sh[10:9]};
        b = {sh[4:0],   sh[4:2]};
      end
      default: begin r = w[23:16]; g = w[15:8]; b = w[7:0]; end
    endcase
    pixel_fmt = swap ? {b, g, r} : {r, g, b};
  endfunction

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   cur_q, cur_d;
  logic          cur_vld_q, cur_vld_d;
  logic [4:0]    idx_q, idx_d;
  logic [23:0]   lcdvd_q, lcdvd_d;
  logic          underflow_q, underflow_d;

  logic          wr_ready_s, push_s, emit_s, last_s, load_s, set_uf_s;
  logic [5:0]    ppw_s;
  logic [23:0]   pix_s;

  // Handshake, unpacker control and pixel formatting from registered state.
  always_comb begin
    wr_ready_s = !rst && lcd_en && (level_q < LW'(FIFO_DEPTH));
    push_s     = wr.wr_valid && wr_ready_s;
    ppw_s      = (bpp_bits(lcd_bpp) == 6'd24) ? 6'd1 : (6'd32 / bpp_bits(lcd_bpp));
    emit_s     = lcd_en && pixel_disp_on && cur_vld_q;
    // >= rather than == so a bpp change mid-word cannot run the index away.
    last_s     = ({1'b0, idx_q} >= (ppw_s - 6'd1));
    load_s     = lcd_en && !frame_start && (level_q != '0) && (!cur_vld_q || (emit_s && last_s));
    set_uf_s   = lcd_en && pixel_disp_on && !cur_vld_q;
    pix_s      = pixel_fmt(cur_q, idx_q, lcd_bpp, bepo, bgr);
  end

  // Next-state for FIFO pointers/level, current word, output pixel and flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    cur_d       = cur_q;
    cur_vld_d   = cur_vld_q;
    idx_d       = idx_q;
    lcdvd_d     = 24'd0;
    underflow_d = underflow_q;
    if (!lcd_en) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      cur_vld_d = 1'b0;
      idx_d     = 5'd0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (load_s) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        cur_d     = mem_q[rd_ptr_q];
        cur_vld_d = 1'b1;
        idx_d     = 5'd0;
      end else if (frame_start) begin
        cur_vld_d = 1'b0;
        idx_d     = 5'd0;
      end else if (emit_s && last_s) begin
        cur_vld_d = 1'b0;
      end else if (emit_s) begin
        idx_d     = idx_q + 5'd1;
      end else begin
        idx_d     = idx_q;
      end
      case ({push_s, load_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      lcdvd_d = emit_s ? pix_s : 24'd0;
    end
    // A set in the same cycle as a clear wins.
    if (set_uf_s)           underflow_d = 1'b1;
    else if (underflow_clr) underflow_d = 1'b0;
    else                    underflow_d = underflow_q;
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge pixel_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr.wr_data;
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cur_q       <= 32'd0;
      cur_vld_q   <= 1'b0;
      idx_q       <= 5'd0;
      lcdvd_q     <= 24'd0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cur_q       <= cur_d;
      cur_vld_q   <= cur_vld_d;
      idx_q       <= idx_d;
      lcdvd_q     <= lcdvd_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr.wr_ready = wr_ready_s;
  assign LCDVD       = lcdvd_q;
  assign fifo_level  = level_q;
  assign underflow   = underflow_q;
  assign dma_req     = !rst && lcd_en && (level_q <= LW'(WM_LEVEL));
endmodule

// File: tb/tb_lcd_pixel_serializer.sv
// Self-checking bench for lcd_pixel_serializer: directed scenarios plus a
// randomized run, all tracked by a queue-based reference model.
module tb_lcd_pixel_serializer;
  localparam int DEPTH = 16;
  localparam int WM    = 4;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1, lcd_en = 1'b0, bepo = 1'b0, bgr = 1'b0;
  logic [2:0]  lcd_bpp = 3'd0;
  logic        pixel_disp_on = 1'b0, frame_start = 1'b0, underflow_clr = 1'b0;
  logic [23:0] LCDVD;
  logic [4:0]  fifo_level;
  logic        dma_req, underflow;

  lcd_pixel_serializer_if wr_if();

  lcd_pixel_serializer #(.FIFO_DEPTH(DEPTH), .WM_LEVEL(WM)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .lcd_en(lcd_en), .lcd_bpp(lcd_bpp),
    .bepo(bepo), .bgr(bgr), .wr(wr_if.slave), .pixel_disp_on(pixel_disp_on),
    .frame_start(frame_start), .underflow_clr(underflow_clr), .LCDVD(LCDVD),
    .fifo_level(fifo_level), .dma_req(dma_req), .underflow(underflow));

  always #5 pixel_clk = ~pixel_clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [31:0] m_q[$];
  logic [31:0] m_word = 32'd0;
  bit          m_vld = 1'b0;
  int          m_idx = 0;
  bit          m_uf = 1'b0;
  logic [23:0] m_lcdvd = 24'd0;

  function automatic int bits_of(logic [2:0] code);
    case (code)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 8;
      3'd4: return 16;
      default: return 24;
    endcase
  endfunction

  function automatic logic [23:0] exp_pixel(logic [31:0] w, int idx, logic [2:0] code, logic be, logic sw);
    int n, sh;
    int unsigned p, r, g, b;
    logic [23:0] px;
    n = bits_of(code);
    if (n == 24) px = w[23:0];
    else begin
      sh = be ? 32 - (idx + 1) * n : idx * n;
      p  = (w >> sh) & ((32'd1 << n) - 32'd1);
      if (n <= 8) begin
        g  = p * 255 / ((32'd1 << n) - 32'd1);
        px = {g[7:0], g[7:0], g[7:0]};
      end else begin
        r = p >> 11; g = (p >> 5) & 63; b = p & 31;
        r = (r << 3) | (r >> 2); g = (g << 2) | (g >> 4); b = (b << 3) | (b >> 2);
        px = {r[7:0], g[7:0], b[7:0]};
      end
    end
    if (sw) px = {px[7:0], px[15:8], px[23:16]};
    return px;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit emit, last, do_push;
    int n, ppw;
    if (rst) begin
      m_q.delete(); m_vld = 0; m_idx = 0; m_uf = 0; m_lcdvd = 24'd0;
      return;
    end
    if (!lcd_en) begin
      m_q.delete(); m_vld = 0; m_idx = 0; m_lcdvd = 24'd0;
      if (underflow_clr) m_uf = 0;
      return;
    end
    n       = bits_of(lcd_bpp);
    ppw     = (n == 24) ? 1 : 32 / n;
    emit    = pixel_disp_on && m_vld;
    do_push = wr_if.wr_valid && (m_q.size() < DEPTH);
    m_lcdvd = emit ? exp_pixel(m_word, m_idx, lcd_bpp, bepo, bgr) : 24'd0;
    if (pixel_disp_on && !m_vld) m_uf = 1;
    else if (underflow_clr)      m_uf = 0;
    last = emit && (m_idx + 1 >= ppw);
    if (m_q.size() > 0 && !frame_start && (!m_vld || last)) begin
      m_word = m_q.pop_front(); m_vld = 1; m_idx = 0;
    end else if (frame_start) begin
      m_vld = 0; m_idx = 0;
    end else if (last) m_vld = 0;
    else if (emit) m_idx++;
    if (do_push) m_q.push_back(wr_if.wr_data);
  endtask

  task automatic tick();
    model_step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic push_word(logic [31:0] w);
    wr_if.wr_valid = 1'b1; wr_if.wr_data = w;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lcd_en = 1'b1; pixel_disp_on = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_data = $urandom;
    tick(); tick();
    tests_run++; if (LCDVD !== 24'd0) begin tests_failed++; $display("FAIL reset_lcdvd got %h want 0", LCDVD); end
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_underflow got %b want 0", underflow); end
    tests_run++; if (dma_req !== 1'b0 || wr_if.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready got %b%b want 00", dma_req, wr_if.wr_ready); end
    rst = 1'b0; pixel_disp_on = 1'b0; wr_if.wr_valid = 1'b0;
    tick();
    tests_run++; if (wr_if.wr_ready !== 1'b1 || dma_req !== 1'b1 || fifo_level !== 5'd0) begin tests_failed++; $display("FAIL resume got ready=%b req=%b lvl=%0d want 1 1 0", wr_if.wr_ready, dma_req, fifo_level); end
  endtask

  task automatic test_rgb24();
    lcd_bpp = 3'd5; bepo = 1'b0; bgr = 1'b0;
    push_word(32'h0012_3456); tick();
    pixel_disp_on = 1'b1; tick(); pixel_disp_on = 1'b0;
    tests_run++; if (LCDVD !== 24'h123456) begin tests_failed++; $display("FAIL rgb24 got %h want 123456", LCDVD); end
    tick();
    tests_run++; if (LCDVD !== 24'h000000) begin tests_failed++; $display("FAIL blank got %h want 000000", LCDVD); end
    bgr = 1'b1;
    push_word(32'h0012_3456); tick();
    pixel_disp_on = 1'b1; tick(); pixel_disp_on = 1'b0;
    tests_run++; if (LCDVD !== 24'h563412) begin tests_failed++; $display("FAIL rgb24_bgr got %h want 563412", LCDVD); end
    bgr = 1'b0;
  endtask

  task automatic test_rgb565();
    logic [23:0] exp0, exp1;
    lcd_bpp = 3'd4;
    for (int be = 0; be < 2; be++) begin
      bepo = be[0];
      exp0 = be ? 24'h180000 : 24'h001C00;
      exp1 = be ? 24'h001C00 : 24'h180000;
      push_word(32'h1800_00E0); tick();
      pixel_disp_on = 1'b1;
      tick();
      tests_run++; if (LCDVD !== exp0) begin tests_failed++; $display("FAIL rgb565_p0 bepo=%0d got %h want %h", be, LCDVD, exp0); end
      tick();
      tests_run++; if (LCDVD !== exp1) begin tests_failed++; $display("FAIL rgb565_p1 bepo=%0d got %h want %h", be, LCDVD, exp1); end
      pixel_disp_on = 1'b0;
    end
  endtask

  task automatic test_1bpp();
    logic [23:0] ev;
    logic [4:0]  el;
    lcd_bpp = 3'd0; bepo = 1'b1;
    push_word(32'h8000_0001);
    push_word($urandom);
    pixel_disp_on = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      ev = (i == 0 || i == 31) ? 24'hFFFFFF : 24'h000000;
      el = (i == 31) ? 5'd0 : 5'd1;
      tests_run++; if (LCDVD !== ev || fifo_level !== el) begin tests_failed++; $display("FAIL bpp1 px%0d got %h/%0d want %h/%0d", i, LCDVD, fifo_level, ev, el); end
    end
    pixel_disp_on = 1'b0;
  endtask

  task automatic test_underflow();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pixel_disp_on = 1'b1; tick(); pixel_disp_on = 1'b0;
    tests_run++; if (LCDVD !== 24'd0 || underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_set got %h/%b want 0/1", LCDVD, underflow); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_frame got %b want 1", underflow); end
    underflow_clr = 1'b1; tick();
    tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clr got %b want 0", underflow); end
    pixel_disp_on = 1'b1; tick(); pixel_disp_on = 1'b0;
    tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_setwins got %b want 1", underflow); end
    tick(); underflow_clr = 1'b0;
    tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clr2 got %b want 0", underflow); end
  endtask

  task automatic test_full();
    int acc = 0;
    lcd_bpp = 3'd5;
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_if.wr_data = $urandom;
      if (wr_if.wr_ready) acc++;
      tick();
    end
    wr_if.wr_valid = 1'b0;
    tests_run++; if (acc != 17) begin tests_failed++; $display("FAIL full_accepted got %0d want 17", acc); end
    tests_run++; if (wr_if.wr_ready !== 1'b0 || fifo_level !== 5'd16 || dma_req !== 1'b0) begin tests_failed++; $display("FAIL full_state got rdy=%b lvl=%0d req=%b want 0 16 0", wr_if.wr_ready, fifo_level, dma_req); end
    pixel_disp_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (fifo_level !== 5'(m_q.size()) || dma_req !== (m_q.size() <= WM) || LCDVD !== m_lcdvd) begin
        tests_failed++;
        $display("FAIL drain%0d got lvl=%0d req=%b px=%h want %0d %b %h", i, fifo_level, dma_req, LCDVD, m_q.size(), m_q.size() <= WM, m_lcdvd);
      end
    end
    pixel_disp_on = 1'b0; underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
  endtask

  task automatic test_reset_midword();
    lcd_bpp = 3'd3; bepo = 1'b0;
    push_word(32'h4433_2211); tick();
    pixel_disp_on = 1'b1;
    tick();
    tests_run++; if (LCDVD !== 24'h111111) begin tests_failed++; $display("FAIL mid_p0 got %h want 111111", LCDVD); end
    tick();
    tests_run++; if (LCDVD !== 24'h222222) begin tests_failed++; $display("FAIL mid_p1 got %h want 222222", LCDVD); end
    rst = 1'b1; wr_if.wr_valid = 1'b1; wr_if.wr_data = $urandom;
    tick();
    tests_run++; if (LCDVD !== 24'd0 || fifo_level !== 5'd0 || underflow !== 1'b0 || dma_req !== 1'b0 || wr_if.wr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset got %h %0d %b %b %b want all 0", LCDVD, fifo_level, underflow, dma_req, wr_if.wr_ready);
    end
    rst = 1'b0; wr_if.wr_valid = 1'b0; pixel_disp_on = 1'b0;
    push_word(32'hDDCC_BBAA); tick();
    pixel_disp_on = 1'b1; tick(); pixel_disp_on = 1'b0;
    tests_run++; if (LCDVD !== 24'hAAAAAA) begin tests_failed++; $display("FAIL mid_fresh got %h want AAAAAA", LCDVD); end
  endtask

  task automatic test_disable();
    push_word($urandom); push_word($urandom);
    lcd_en = 1'b0; pixel_disp_on = 1'b1; wr_if.wr_valid = 1'b1;
    tick();
    tests_run++; if (LCDVD !== 24'd0 || fifo_level !== 5'd0 || dma_req !== 1'b0 || wr_if.wr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL disable got %h %0d %b %b want 0 0 0 0", LCDVD, fifo_level, dma_req, wr_if.wr_ready);
    end
    lcd_en = 1'b1; wr_if.wr_valid = 1'b0;
    tick();
    tests_run++; if (LCDVD !== 24'd0 || underflow !== 1'b1) begin tests_failed++; $display("FAIL disable_flush got %h/%b want 0/1", LCDVD, underflow); end
    pixel_disp_on = 1'b0; underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
  endtask

  task automatic test_random();
    for (int batch = 0; batch < 8; batch++) begin
      pixel_disp_on = 1'b0; wr_if.wr_valid = 1'b0; lcd_en = 1'b1;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      lcd_bpp = 3'($urandom_range(0, 7)); bepo = 1'($urandom); bgr = 1'($urandom);
      for (int c = 0; c < 250; c++) begin
        wr_if.wr_valid = ($urandom_range(0, 2) != 0);
        wr_if.wr_data  = $urandom;
        pixel_disp_on  = ($urandom_range(0, 3) != 0);
        frame_start    = ($urandom_range(0, 60) == 0);
        underflow_clr  = ($urandom_range(0, 15) == 0);
        lcd_en         = ($urandom_range(0, 120) != 0);
        tick();
        tests_run++;
        if (LCDVD !== m_lcdvd || fifo_level !== 5'(m_q.size()) || underflow !== m_uf ||
            wr_if.wr_ready !== (lcd_en && m_q.size() < DEPTH) || dma_req !== (lcd_en && m_q.size() <= WM)) begin
          tests_failed++;
          $display("FAIL random b%0d c%0d got px=%h lvl=%0d uf=%b rdy=%b req=%b want px=%h lvl=%0d uf=%b",
                   batch, c, LCDVD, fifo_level, underflow, wr_if.wr_ready, dma_req, m_lcdvd, m_q.size(), m_uf);
        end
      end
    end
    frame_start = 1'b0; underflow_clr = 1'b0; pixel_disp_on = 1'b0; wr_if.wr_valid = 1'b0; lcd_en = 1'b1;
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 32'd0;
    test_reset();
    test_rgb24();
    test_rgb565();
    test_1bpp();
    test_underflow();
    test_full();
    test_reset_midword();
    test_disable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
